// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter for one FIFO write port, with FIFO reset sequencing after power-up.
// Define FIFO_WR_ARB_PRIO0_EN to give requester 0 strict priority at arbitration time.
module fifo_wr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 9,
  parameter int BURST_MAX   = 16,
  parameter int INIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         fifo_dia,
  output logic                  fifo_we,
  output logic                  fifo_rst,
  input  logic                  fifo_afull_flag,
  input  logic                  fifo_full_flag,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  init_done,
  output logic                  ovf_err
);
  typedef enum logic [1:0] {INIT, IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [2:0] grant_id_q, grant_id_d, ptr_q, ptr_d, rr_sel;
  logic [DW-1:0] fifo_dia_q, fifo_dia_d, gnt_data;
  logic fifo_we_q, fifo_we_d, fifo_rst_q, fifo_rst_d;
  logic init_done_q, init_done_d, ovf_err_q, ovf_err_d;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [2*NUM_REQ-1:0] rot;
  logic acc, gnt_last;
  assign gnt_oh    = NUM_REQ'(1) << grant_id_q;
  assign req_ready = (state_q == GRANT && !fifo_afull_flag) ? gnt_oh : '0;
  assign acc       = |(req_valid & req_ready);
  assign gnt_last  = |(req_last & gnt_oh);
  // valids rotated so bit 0 is the requester just after the pointer
  assign rot = {req_valid, req_valid} >> ({1'b0, ptr_q} + 4'd1);
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id_q == 3'(i)) gnt_data = req_data[i*DW +: DW];
  end
  always_comb begin
    rr_sel = ptr_q;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (rot[i]) rr_sel = 3'((int'(ptr_q) + 1 + i) % NUM_REQ);
  end
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    fifo_dia_d  = fifo_dia_q;
    fifo_we_d   = 1'b0;
    fifo_rst_d  = fifo_rst_q;
    init_done_d = init_done_q;
    ovf_err_d   = ovf_err_q | (fifo_we_q & fifo_full_flag);
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == 4'(INIT_CYCLES-1)) begin
          fifo_rst_d  = 1'b0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: if (!fifo_afull_flag && |req_valid) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
        grant_id_d = req_valid[0] ? 3'd0 : rr_sel;
        ptr_d      = req_valid[0] ? ptr_q : rr_sel;
`else
        grant_id_d = rr_sel;
        ptr_d      = rr_sel;
`endif
        beat_cnt_d = '0;
        state_d    = GRANT;
      end
      default: if (acc) begin
        fifo_we_d  = 1'b1;
        fifo_dia_d = gnt_data;
        beat_cnt_d = beat_cnt_q + 8'd1;
        if (gnt_last || beat_cnt_d == 8'(BURST_MAX)) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      grant_id_q  <= 3'(NUM_REQ-1);
      ptr_q       <= 3'(NUM_REQ-1);
      fifo_dia_q  <= '0;
      fifo_we_q   <= 1'b0;
      fifo_rst_q  <= 1'b1;
      init_done_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      fifo_dia_q  <= fifo_dia_d;
      fifo_we_q   <= fifo_we_d;
      fifo_rst_q  <= fifo_rst_d;
      init_done_q <= init_done_d;
      ovf_err_q   <= ovf_err_d;
    end
  end
  assign fifo_dia  = fifo_dia_q;
  assign fifo_we   = fifo_we_q;
  assign fifo_rst  = fifo_rst_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == GRANT);
  assign init_done = init_done_q;
  assign ovf_err   = ovf_err_q;
endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
Round-robin arbiter that shares the single write port of one FIFO8K-mode FIFO primitive among NUM_REQ requesters.
- Grants whole bursts, so one requester owns the port until its last beat or BURST_MAX beats.
- Throttles on the FIFO almost-full flag.
- Sequences the FIFO reset after power-up.
- Sits between the requester datapaths and the FIFO write side (dia/we/rst); the read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 9, data width per beat; matches the FIFO write width (1,2,4,9,18)
BURST_MAX, 16, maximum beats per grant before forced re-arbitration (1..255)
INIT_CYCLES, 4, cycles fifo_rst is held high after reset release (1..15)

Ports:
clk  in  1  single clock; drives arbiter and FIFO write clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last beat of burst, qualified by valid
req_data  in  NUM_REQ*DW  per-requester beat data; requester i at [i*DW +: DW]
req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero
fifo_dia  out  DW  registered write data to FIFO
fifo_we  out  1  registered write enable to FIFO
fifo_rst  out  1  active-high reset to FIFO
fifo_afull_flag  in  1  FIFO almost-full flag
fifo_full_flag  in  1  FIFO full flag
grant_id  out  3  index of current/last granted requester
busy  out  1  high in GRANT state
init_done  out  1  high once INIT completes
ovf_err  out  1  sticky: write issued while full

Behaviour:
- Reset (rst_n low, asynchronous) forces these values:
  - state = INIT, fifo_rst = 1, fifo_we = 0, fifo_dia = 0.
  - req_ready = 0, grant_id = NUM_REQ-1 (so requester 0 is first in round-robin order).
  - busy = 0, init_done = 0, ovf_err = 0, beat counter = 0, init counter = 0.
- INIT state:
  - fifo_rst held 1 for INIT_CYCLES clk edges after rst_n rises.
  - Then fifo_rst = 0, init_done = 1, go to IDLE.
  - init_done stays 1 until the next rst_n assertion.
- IDLE state:
  - If fifo_afull_flag = 0 and any req_valid is high, select the first valid index after grant_id in round-robin order (wrapping NUM_REQ-1 to 0).
  - Register it into grant_id, clear the beat counter, go to GRANT.
  - Arbitration costs one cycle; req_ready = 0 throughout IDLE.
  - If fifo_afull_flag = 1, stay in IDLE regardless of requests.
- GRANT state:
  - busy = 1.
  - req_ready[grant_id] = !fifo_afull_flag; all other req_ready bits = 0.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - On an accepted beat: next cycle fifo_we = 1 and fifo_dia = req_data of g (write latency 1). Otherwise fifo_we = 0 next cycle and fifo_dia holds its value.
  - The beat counter increments on each accepted beat.
  - Return to IDLE on the cycle after an accepted beat with req_last = 1, or on the beat that makes the count equal BURST_MAX, whichever comes first. grant_id is retained as the round-robin pointer.
  - Stall (afull high, or valid low) holds GRANT with no timeout.
- Back-to-back bursts: minimum one IDLE cycle between bursts; fifo_we may be high during that IDLE cycle (trailing write).
- Flow-control margin: the FIFO almost-full threshold must leave at least 2 free entries so the in-flight registered write never overflows.
- ovf_err: set when fifo_we = 1 and fifo_full_flag = 1 in the same cycle; cleared only by rst_n.
- Reset mid-burst: everything returns to reset values and INIT reruns. A partial burst is not resumed.
- req_last with BURST_MAX reached on the same beat: a single return to IDLE, no double pointer update.
- The arbiter never grants during INIT, even with requests pending.

Optional Feature:
- Macro FIFO_WR_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority in IDLE. If req_valid[0] = 1, grant 0 regardless of grant_id. Other requesters use round-robin among themselves, with the pointer updated only by non-0 grants.
- Undefined: pure round-robin as above.
- Burst ownership is unchanged in both cases; requester 0 never preempts a running burst.

Test Plan:
1. Reset release, no requests:
   - fifo_rst = 1 for exactly 4 cycles, then 0; init_done rises the same cycle fifo_rst falls.
   - fifo_we stays 0.
2. All 4 requesters issue continuous single-beat bursts (last = 1) from the start:
   - grant_id sequence 0,1,2,3,0; each beat appears on fifo_dia one cycle after its req_ready handshake.
3. Requester 2 drives a 20-beat burst with last only on beat 20:
   - 16 beats written, then IDLE, grant passes to requester 3 if valid.
   - Requester 2 resumes on its next turn with the remaining 4 beats.
4. Hold fifo_afull_flag = 1 for 5 cycles mid-burst:
   - req_ready = 0 for those 5 cycles, no fifo_we after the in-flight write.
   - Burst resumes with no lost or duplicated data.
5. Force fifo_full_flag = 1 while a write is issued:
   - ovf_err sets and stays set until rst_n.
   - Assert rst_n low mid-burst: all outputs return to reset values and INIT repeats.
6. With FIFO_WR_ARB_PRIO0_EN defined, requesters 0 and 1 continuously valid with single-beat bursts:
   - Grants 0,0,0,...; requester 1 is granted only when req_valid[0] drops.
